// File: rtl/alu_result_queue.sv
// alu_result_queue
// ----------------
// Result FIFO behind the 16-bit adder ALU. Each accepted ALU result
// (sum plus five flags) is stored unmodified and presented at the head
// with valid/ready handshakes on both sides. Sticky carry/overflow bits and
// a saturating overflow-event counter are kept for software polling.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   producer handshake (in_ready from registered state only)
//   in_z, in_sign, in_zero, in_carry, in_parity, in_overflow   ALU result
//   out_valid/out_ready consumer handshake
//   out_z, out_flags    head entry; flags = {overflow, parity, carry, zero, sign}
//   count               current occupancy (0..DEPTH)
//   clr_sticky          synchronous clear of sticky bits and ovf_count
//   sticky_carry, sticky_ovf, ovf_count   status, updated on accepted pushes
module alu_result_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_z,
  input  logic                     in_sign,
  input  logic                     in_zero,
  input  logic                     in_carry,
  input  logic                     in_parity,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_z,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic                     sticky_carry,
  output logic                     sticky_ovf,
  output logic [7:0]               ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 5;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_reg;
  logic          sticky_carry_reg;
  logic          sticky_ovf_reg;
  logic [7:0]    ovf_count_reg;

  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Readiness comes from the occupancy register alone, so a full queue
  // refuses a push even when a pop happens in the same cycle.
  assign in_ready  = (count_reg < (AW+1)'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is cleared on reset so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {in_overflow, in_parity, in_carry, in_zero, in_sign, in_z};
    end
  end

  // DEPTH is a power of two, so the natural AW-bit rollover is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Status: a clear in the same cycle as a push keeps the pushed event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry_reg <= 1'b0;
      sticky_ovf_reg   <= 1'b0;
      ovf_count_reg    <= 8'd0;
    end else begin
      sticky_carry_reg <= (sticky_carry_reg & ~clr_sticky) | (push & in_carry);
      sticky_ovf_reg   <= (sticky_ovf_reg & ~clr_sticky) | (push & in_overflow);
      if (push) begin
        if (clr_sticky) begin
          ovf_count_reg <= {7'd0, in_overflow};
        end else if (in_overflow && (ovf_count_reg != 8'hFF)) begin
          ovf_count_reg <= ovf_count_reg + 8'd1;
        end
      end else if (clr_sticky) begin
        ovf_count_reg <= 8'd0;
      end
    end
  end

  assign head         = mem[rd_ptr];
  assign out_z        = head[WIDTH-1:0];
  assign out_flags    = head[EW-1:WIDTH];
  assign count        = count_reg;
  assign sticky_carry = sticky_carry_reg;
  assign sticky_ovf   = sticky_ovf_reg;
  assign ovf_count    = ovf_count_reg;

endmodule

// File: tb/tb_alu_result_queue.sv
// Testbench for alu_result_queue: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// queue-based behavioural model.
module tb_alu_result_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_z = '0;
  logic              in_sign = 1'b0, in_zero = 1'b0, in_carry = 1'b0;
  logic              in_parity = 1'b0, in_overflow = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_z;
  logic [4:0]        out_flags;
  logic [2:0]        count;
  logic              clr_sticky = 1'b0;
  logic              sticky_carry, sticky_ovf;
  logic [7:0]        ovf_count;

  int checks = 0;
  int failures = 0;

  alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_sign(in_sign), .in_zero(in_zero), .in_carry(in_carry),
    .in_parity(in_parity), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags), .count(count),
    .clr_sticky(clr_sticky), .sticky_carry(sticky_carry),
    .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [20:0] m_q[$];
  bit          m_sc, m_so;
  int          m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_sc = 0; m_so = 0; m_ovf = 0;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (m_q.size() < DEPTH);
      do_pop  = (m_q.size() != 0) && out_ready;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back({in_overflow, in_parity, in_carry, in_zero, in_sign, in_z});
      if (clr_sticky) begin m_sc = 0; m_so = 0; m_ovf = 0; end
      if (do_push && in_carry) m_sc = 1;
      if (do_push && in_overflow) begin
        m_so = 1;
        if (m_ovf < 255) m_ovf++;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("count", 32'(count), 32'(m_q.size()));
    check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("sticky_carry", 32'(sticky_carry), 32'(m_sc));
    check("sticky_ovf", 32'(sticky_ovf), 32'(m_so));
    check("ovf_count", 32'(ovf_count), 32'(m_ovf));
    if (m_q.size() != 0) begin
      logic [20:0] h;
      h = m_q[0];
      check("out_z", 32'(out_z), 32'(h[15:0]));
      check("out_flags", 32'(out_flags), 32'(h[20:16]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] z, input logic [4:0] f);
    in_valid = v; in_z = z;
    {in_overflow, in_parity, in_carry, in_zero, in_sign} = f;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    out_ready = 0;
  endtask

  initial begin
    // reset state
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_z", 32'(out_z), 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // Fill / drain
    out_ready = 0;
    for (int i = 1; i <= 4; i++) begin set_in(1, 16'(i), 5'b0); tick(); end
    check("fill_count", 32'(count), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    set_in(1, 16'h0005, 5'b0); tick();
    check("full_hold_count", 32'(count), 4);
    check("full_head", 32'(out_z), 1);
    in_valid = 0; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_z", 32'(out_z), 32'(i));
      tick();
    end
    check("drain_empty", 32'(out_valid), 0);

    // Streaming and wrap: 20 pushes with consumer always ready
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      set_in(1, 16'(16'h0100 + i), 5'b0); tick();
      check("stream_count", 32'(count), 1);
      check("stream_z", 32'(out_z), 32'(16'h0100 + i));
    end
    drain();

    // Flags passthrough: 0x7FFF + 0x0001
    clr_sticky = 1; tick(); clr_sticky = 0;
    set_in(1, 16'h8000, 5'b10001); tick(); in_valid = 0;
    check("pass_flags", 32'(out_flags), 32'h11);
    check("pass_z", 32'(out_z), 32'h8000);
    check("pass_sticky_ovf", 32'(sticky_ovf), 1);
    check("pass_ovf_count", 32'(ovf_count), 1);
    drain();

    // Sticky clear race
    clr_sticky = 1; set_in(1, 16'h0000, 5'b00110); tick();
    check("race_sticky_carry", 32'(sticky_carry), 1);
    check("race_sticky_ovf", 32'(sticky_ovf), 0);
    check("race_ovf_count", 32'(ovf_count), 0);
    in_valid = 0; tick();
    check("clr_sticky_carry", 32'(sticky_carry), 0);
    clr_sticky = 0;
    drain();

    // Saturation
    out_ready = 1;
    for (int i = 0; i < 300; i++) begin set_in(1, 16'(i), 5'b10000); tick(); end
    in_valid = 0; tick();
    check("sat_ovf_count", 32'(ovf_count), 255);
    tick();
    check("sat_hold", 32'(ovf_count), 255);
    clr_sticky = 1; tick(); clr_sticky = 0;
    check("sat_clr", 32'(ovf_count), 0);
    drain();

    // Reset mid-stream with 3 entries queued
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin set_in(1, 16'(16'hA0 + i), 5'b11111); tick(); end
    in_valid = 0;
    check("pre_rst_count", 32'(count), 3);
    rst_n = 0; #1;
    check("arst_count", 32'(count), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_out_z", 32'(out_z), 0);
    check("arst_sticky", 32'({sticky_carry, sticky_ovf}), 0);
    check("arst_ovf_count", 32'(ovf_count), 0);
    tick(); rst_n = 1; tick();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 16'($urandom), 5'($urandom));
      out_ready  = 1'($urandom_range(0, 2) != 0);
      clr_sticky = 1'($urandom_range(0, 40) == 0);
      tick();
    end
    set_in(0, 16'h0, 5'b0); clr_sticky = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
